frame_dispatch_ctrl: RTL
========================

# frame_dispatch_ctrl

Frame dispatch controller between the arbitration FIFO and the processing engine. Pops tagged words {source, mode, proc value, pixel} from the FIFO, checks that every pixel of a frame carries one consistent mode, and hands pixels to the engine over a valid/ready handshake. After FRAME_PIX pixels have been accepted and the engine has drained, it pulses `mstr0_cmplt`, which upstream uses to stop granting slaves.

## Interface
- `DW`, 32, pixel data width
- `FRAME_PIX`, 64, pixels per frame (≥2)
- `CW`, $clog2(FRAME_PIX+1), pixel counter width

- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `fifo_empty` in 1: FIFO has no word
- `fifo_rd_en` out 1: pop request; the word appears on `fifo_rdata` the following cycle
- `fifo_rdata` in DW+11: {src[DW+10], mode[DW+9:DW+8], proc_val[DW+7:DW], data[DW-1:0]}
- `eng_valid` out 1: pixel presented to engine
- `eng_ready` in 1: engine accepts the pixel
- `eng_data` out DW: pixel
- `eng_mode` out 2: mode of the pixel
- `eng_proc_val` out 8: per-pixel processing value
- `eng_src` out 1: originating slave (0/1)
- `eng_busy` in 1: engine still processing accepted pixels
- `mstr0_cmplt` out 1: one-cycle frame-complete pulse
- `pix_cnt` out CW: pixels accepted in the current frame
- `frame_cnt` out 16: completed frames, wraps at 0xFFFF→0
- `err_clr` in 1: clears `err_mode`
- `err_mode` out 1: sticky; a word was dropped for a bad mode
- `ctrl_busy` out 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, READ, CHECK, HOLD, DRAIN, CMPLT.
- IDLE: `fifo_rd_en = !fifo_empty` (combinational). If the FIFO is non-empty, go to READ.
- READ: the word is valid on `fifo_rdata`. Register it into the eng_* output registers and go to CHECK.
- CHECK: validates the registered word.
  - If mode==2'b00, or `pix_cnt`≠0 and mode≠`frame_mode`, the word is dropped and `err_mode` is set. Next state is READ if `!fifo_empty` (with `fifo_rd_en`=1), otherwise IDLE.
  - Otherwise, if `pix_cnt`==0, latch `frame_mode`. Go to HOLD.
- HOLD: `eng_valid`=1, and all eng_* outputs stay stable until `eng_ready`. On the transfer (`eng_valid && eng_ready`), `pix_cnt` increments.
  - If it was the last pixel (`pix_cnt`==FRAME_PIX-1 before the increment), go to DRAIN.
  - Else if `!fifo_empty`, assert `fifo_rd_en` that cycle and go to READ.
  - Else go to IDLE.
- DRAIN: wait for `eng_busy`==0, then go to CMPLT. No FIFO reads occur in DRAIN.
- CMPLT: `mstr0_cmplt`=1 for exactly one cycle. `frame_cnt` increments, `pix_cnt` clears to 0, `frame_mode` clears. Go to IDLE.
- `err_mode`:
  - A drop sets it in the same cycle (visible next cycle).
  - `err_clr` clears it.
  - If a drop and `err_clr` coincide, set wins.
- `fifo_rd_en` is never asserted while `fifo_empty`=1.

## Timing
- Reset (asynchronous assert) forces:
  - state=IDLE
  - `fifo_rd_en`=0, `eng_valid`=0
  - eng_data/mode/proc_val/src=0
  - `mstr0_cmplt`=0, `pix_cnt`=0, `frame_cnt`=0, `err_mode`=0, `ctrl_busy`=0
- Reset mid-frame discards the in-flight word and any partial frame; no completion pulse is produced.
- Latency from FIFO to engine: `fifo_rd_en` in cycle N, capture at the end of N+1, CHECK in N+2, `eng_valid` first high in N+3.
- Throughput with `eng_ready` held at 1 and a non-empty FIFO: one pixel every 3 cycles.
- `eng_ready` may be high before `eng_valid`; the transfer occurs on the first HOLD cycle.
- An `eng_ready` low for k cycles extends HOLD by k cycles; the outputs must not change.
- Last transfer, DRAIN, and CMPLT:
  - With `eng_busy`=0 in the cycle after the last transfer, DRAIN lasts 1 cycle and `mstr0_cmplt` rises 2 cycles after the last transfer.
  - A new frame's first `fifo_rd_en` occurs no earlier than the cycle after CMPLT.

## Test plan
- Basic frame:
  - Stimulus: FRAME_PIX=4; 4 words with mode=01, data 0x10..0x13; `eng_ready`=1, `eng_busy`=0.
  - Response: engine sees 0x10..0x13 in order, each with eng_mode=01. `pix_cnt` reaches 4, one `mstr0_cmplt` pulse follows, `frame_cnt`=1, `pix_cnt` returns to 0.
- Backpressure:
  - Stimulus: `eng_ready` low for 5 cycles while a word with data=0xA5A5A5A5, proc_val=0x3C is held.
  - Response: `eng_valid` stays high and eng_data/eng_proc_val are unchanged for all 5 cycles; exactly one transfer occurs.
- Mode errors:
  - Stimulus: frame starts with mode=10; the 2nd word has mode=01 and the 3rd word has mode=00.
  - Response: both words are dropped and never reach the engine. `err_mode`=1 and `pix_cnt` stays at 1. Pulsing `err_clr` returns `err_mode` to 0.
- Drain wait:
  - Stimulus: `eng_busy`=1 for 6 cycles after the last transfer.
  - Response: `mstr0_cmplt` stays 0 during those cycles and pulses exactly once, 1 cycle after `eng_busy` falls.
- Empty FIFO and reset mid-frame:
  - Stimulus: `fifo_empty` held at 1 after 2 pixels; then `rst` asserted in HOLD.
  - Response: `fifo_rd_en` stays 0 while the FIFO is empty. After reset all outputs are 0, `pix_cnt`=0, and no `mstr0_cmplt` pulse occurs.
- Counter wrap:
  - Stimulus: preload `frame_cnt` to 0xFFFF (via forced frames), then complete one more frame.
  - Response: `frame_cnt`=0x0000.

Source files
------------

// File: rtl/frame_dispatch_ctrl.sv
// Frame dispatch controller: pops tagged words from the arbitration FIFO,
// enforces a single mode per frame, hands pixels to the engine over a
// valid/ready handshake and signals frame completion once the engine drains.
//
// Handshake: a pixel moves to the engine in any cycle where eng_valid and
// eng_ready are both high. eng_valid never drops and eng_* never change
// until that transfer happens. eng_ready may be high before eng_valid.
module frame_dispatch_ctrl #(
  parameter int DW        = 32,
  parameter int FRAME_PIX = 64,
  parameter int CW        = $clog2(FRAME_PIX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW+10:0] fifo_rdata,
  output logic          eng_valid,
  input  logic          eng_ready,
  output logic [DW-1:0] eng_data,
  output logic [1:0]    eng_mode,
  output logic [7:0]    eng_proc_val,
  output logic          eng_src,
  input  logic          eng_busy,
  output logic          mstr0_cmplt,
  output logic [CW-1:0] pix_cnt,
  output logic [15:0]   frame_cnt,
  input  logic          err_clr,
  output logic          err_mode,
  output logic          ctrl_busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4,
    CMPLT = 3'd5
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] frame_mode_q;
  logic       bad_mode;
  logic       last_pix;
  logic       drop;
  logic       xfer;

  // The first accepted pixel of a frame defines the mode; mode 00 is never legal.
  assign bad_mode = (eng_mode == 2'b00) ||
                    ((pix_cnt != '0) && (eng_mode != frame_mode_q));
  assign last_pix = (pix_cnt == CW'(FRAME_PIX - 1));

  assign eng_valid   = (state_q == HOLD);
  assign mstr0_cmplt = (state_q == CMPLT);
  assign ctrl_busy   = (state_q != IDLE);

  // Next-state logic; every FIFO pop is gated by !fifo_empty.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    drop       = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = READ;
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        if (bad_mode) begin
          drop = 1'b1;
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_d    = READ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (eng_ready) begin
          xfer = 1'b1;
          if (last_pix) begin
            state_d = DRAIN;
          end else if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_d    = READ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (!eng_busy) state_d = CMPLT;
      end
      CMPLT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the popped word; it stays frozen through CHECK and HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_data     <= '0;
      eng_mode     <= 2'b00;
      eng_proc_val <= 8'h00;
      eng_src      <= 1'b0;
    end else if (state_q == READ) begin
      eng_src      <= fifo_rdata[DW+10];
      eng_mode     <= fifo_rdata[DW+9:DW+8];
      eng_proc_val <= fifo_rdata[DW+7:DW];
      eng_data     <= fifo_rdata[DW-1:0];
    end
  end

  // Per-frame bookkeeping: pixel count, frame mode and completed-frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt      <= '0;
      frame_mode_q <= 2'b00;
      frame_cnt    <= 16'h0000;
    end else if (state_q == CMPLT) begin
      pix_cnt      <= '0;
      frame_mode_q <= 2'b00;
      frame_cnt    <= frame_cnt + 16'd1;
    end else begin
      if (xfer) pix_cnt <= pix_cnt + CW'(1);
      if ((state_q == CHECK) && !bad_mode && (pix_cnt == '0))
        frame_mode_q <= eng_mode;
    end
  end

  // Sticky mode error; a drop in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_mode <= 1'b0;
    else if (drop)    err_mode <= 1'b1;
    else if (err_clr) err_mode <= 1'b0;
  end

endmodule
